// File: rtl/mem_arbiter_pkg.sv
// Shared widths, state encoding and defaults for the data-memory bus arbiter.
// Imported by the arbiter top and its round-robin selector.
package mem_arbiter_pkg;

  localparam int CPU_WIDTH           = 32;
  localparam int MEM_SIZE_WIDTH      = 2;
  localparam int ARB_TIMEOUT_DEFAULT = 15;
  // Wide enough for the largest legal TIMEOUT (255).
  localparam int ARB_CNT_W           = 8;

  localparam logic [1:0] ARB_ST_IDLE = 2'd0;
  localparam logic [1:0] ARB_ST_BUSY = 2'd1;
  localparam logic [1:0] ARB_ST_DONE = 2'd2;

  typedef enum logic [1:0] {
    ST_IDLE = ARB_ST_IDLE,
    ST_BUSY = ARB_ST_BUSY,
    ST_DONE = ARB_ST_DONE
  } arb_state_e;

endpackage

// File: rtl/mem_arbiter_rr_pick.sv
// Combinational two-way round-robin selector: a lone request wins outright,
// a contested cycle goes to the master that was not granted last.
module mem_arbiter_rr_pick (
  input  logic [1:0] req,
  input  logic       last_gnt,
  output logic [1:0] pick
);

  always_comb begin
    pick = req;
    if (req == 2'b11) begin
      pick = last_gnt ? 2'b01 : 2'b10;
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// Two-master, single-slave arbiter for the data-memory bus: round-robin grant,
// one latched request/grant/done transaction at a time, timeout watchdog.
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int AW      = CPU_WIDTH,
  parameter int DW      = CPU_WIDTH,
  parameter int SW      = MEM_SIZE_WIDTH,
  parameter int TIMEOUT = ARB_TIMEOUT_DEFAULT
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          m0_req,
  input  logic          m0_we,
  input  logic [SW-1:0] m0_size,
  input  logic [AW-1:0] m0_addr,
  input  logic [DW-1:0] m0_wdata,
  output logic          m0_gnt,
  output logic          m0_done,
  output logic          m0_err,
  input  logic          m1_req,
  input  logic          m1_we,
  input  logic [SW-1:0] m1_size,
  input  logic [AW-1:0] m1_addr,
  input  logic [DW-1:0] m1_wdata,
  output logic          m1_gnt,
  output logic          m1_done,
  output logic          m1_err,
  output logic [DW-1:0] rdata,
  output logic          s_valid,
  output logic          s_we,
  output logic [SW-1:0] s_size,
  output logic [AW-1:0] s_addr,
  output logic [DW-1:0] s_wdata,
  input  logic          s_ready,
  input  logic [DW-1:0] s_rdata
);

  localparam logic [ARB_CNT_W-1:0] TIMEOUT_VAL = ARB_CNT_W'(TIMEOUT);

  arb_state_e           state_q, state_d;
  logic                 last_gnt_q, last_gnt_d;
  logic                 owner_q, owner_d;
  logic [ARB_CNT_W-1:0] cnt_q, cnt_d, cnt_inc;
  logic [1:0]           gnt_q, gnt_d;
  logic [1:0]           done_q, done_d;
  logic [1:0]           err_q, err_d;
  logic                 s_valid_q, s_valid_d;
  logic                 s_we_q, s_we_d;
  logic [SW-1:0]        s_size_q, s_size_d;
  logic [AW-1:0]        s_addr_q, s_addr_d;
  logic [DW-1:0]        s_wdata_q, s_wdata_d;
  logic [DW-1:0]        rdata_q, rdata_d;
  logic [1:0]           req;
  logic [1:0]           pick;

  assign req = {m1_req, m0_req};

  mem_arbiter_rr_pick u_rr_pick (
    .req      (req),
    .last_gnt (last_gnt_q),
    .pick     (pick)
  );

  assign cnt_inc = cnt_q + 1'b1;

  always_comb begin
    state_d    = state_q;
    last_gnt_d = last_gnt_q;
    owner_d    = owner_q;
    cnt_d      = cnt_q;
    gnt_d      = gnt_q;
    done_d     = 2'b00;
    err_d      = 2'b00;
    s_valid_d  = s_valid_q;
    s_we_d     = s_we_q;
    s_size_d   = s_size_q;
    s_addr_d   = s_addr_q;
    s_wdata_d  = s_wdata_q;
    rdata_d    = rdata_q;

    case (state_q)
      ST_IDLE: begin
        if (|pick) begin
          state_d    = ST_BUSY;
          owner_d    = pick[1];
          last_gnt_d = pick[1];
          gnt_d      = pick;
          cnt_d      = '0;
          s_valid_d  = 1'b1;
          if (pick[1]) begin
            s_we_d    = m1_we;
            s_size_d  = m1_size;
            s_addr_d  = m1_addr;
            s_wdata_d = m1_wdata;
          end else begin
            s_we_d    = m0_we;
            s_size_d  = m0_size;
            s_addr_d  = m0_addr;
            s_wdata_d = m0_wdata;
          end
        end
      end

      ST_BUSY: begin
        // A late s_ready on the watchdog's final cycle still counts as success.
        if (s_ready) begin
          if (!s_we_q) begin
            rdata_d = s_rdata;
          end
          s_valid_d       = 1'b0;
          gnt_d           = 2'b00;
          done_d[owner_q] = 1'b1;
          state_d         = ST_DONE;
        end else begin
          cnt_d = cnt_inc;
          if (cnt_inc == TIMEOUT_VAL) begin
            s_valid_d       = 1'b0;
            gnt_d           = 2'b00;
            done_d[owner_q] = 1'b1;
            err_d[owner_q]  = 1'b1;
            state_d         = ST_DONE;
          end
        end
      end

      ST_DONE: begin
        state_d = ST_IDLE;
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      last_gnt_q <= 1'b1;
      owner_q    <= 1'b0;
      cnt_q      <= '0;
      gnt_q      <= 2'b00;
      done_q     <= 2'b00;
      err_q      <= 2'b00;
      s_valid_q  <= 1'b0;
      s_we_q     <= 1'b0;
      s_size_q   <= '0;
      s_addr_q   <= '0;
      s_wdata_q  <= '0;
      rdata_q    <= '0;
    end else begin
      state_q    <= state_d;
      last_gnt_q <= last_gnt_d;
      owner_q    <= owner_d;
      cnt_q      <= cnt_d;
      gnt_q      <= gnt_d;
      done_q     <= done_d;
      err_q      <= err_d;
      s_valid_q  <= s_valid_d;
      s_we_q     <= s_we_d;
      s_size_q   <= s_size_d;
      s_addr_q   <= s_addr_d;
      s_wdata_q  <= s_wdata_d;
      rdata_q    <= rdata_d;
    end
  end

  assign m0_gnt  = gnt_q[0];
  assign m1_gnt  = gnt_q[1];
  assign m0_done = done_q[0];
  assign m1_done = done_q[1];
  assign m0_err  = err_q[0];
  assign m1_err  = err_q[1];
  assign rdata   = rdata_q;
  assign s_valid = s_valid_q;
  assign s_we    = s_we_q;
  assign s_size  = s_size_q;
  assign s_addr  = s_addr_q;
  assign s_wdata = s_wdata_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: reset, contention, wait states, timeout,
// the timeout boundary and reset in the middle of a transaction.
module tb_mem_arbiter;

  logic        clk;
  logic        rst_n;
  logic        m0_req, m0_we, m1_req, m1_we;
  logic [1:0]  m0_size, m1_size;
  logic [31:0] m0_addr, m0_wdata, m1_addr, m1_wdata;
  logic        m0_gnt, m0_done, m0_err, m1_gnt, m1_done, m1_err;
  logic [31:0] rdata;
  logic        s_valid, s_we;
  logic [1:0]  s_size;
  logic [31:0] s_addr, s_wdata;
  logic        s_ready;
  logic [31:0] s_rdata;

  int          n_checks = 0;
  int          n_fail   = 0;
  logic [31:0] exp_rdata;

  mem_arbiter #(.AW(32), .DW(32), .SW(2), .TIMEOUT(15)) dut (
    .clk(clk), .rst_n(rst_n),
    .m0_req(m0_req), .m0_we(m0_we), .m0_size(m0_size), .m0_addr(m0_addr),
    .m0_wdata(m0_wdata), .m0_gnt(m0_gnt), .m0_done(m0_done), .m0_err(m0_err),
    .m1_req(m1_req), .m1_we(m1_we), .m1_size(m1_size), .m1_addr(m1_addr),
    .m1_wdata(m1_wdata), .m1_gnt(m1_gnt), .m1_done(m1_done), .m1_err(m1_err),
    .rdata(rdata), .s_valid(s_valid), .s_we(s_we), .s_size(s_size),
    .s_addr(s_addr), .s_wdata(s_wdata), .s_ready(s_ready), .s_rdata(s_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Mutual exclusion of grants and done pulses, sampled on every falling edge.
  always @(negedge clk) begin
    if (rst_n) begin
      n_checks++;
      if ((m0_gnt & m1_gnt) | (m0_done & m1_done)) begin
        n_fail++;
        $display("FAIL mutex: gnt=%b%b done=%b%b required no overlap", m0_gnt, m1_gnt, m0_done, m1_done);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    m0_req = 0; m0_we = 0; m0_size = 0; m0_addr = 0; m0_wdata = 0;
    m1_req = 0; m1_we = 0; m1_size = 0; m1_addr = 0; m1_wdata = 0;
    s_ready = 0; s_rdata = 0;
    repeat (2) tick();
    n_checks++;
    if ({m0_gnt, m0_done, m0_err, m1_gnt, m1_done, m1_err, s_valid, s_we} !== 8'h00) begin
      n_fail++;
      $display("FAIL reset_ctrl: got %b required 00000000", {m0_gnt, m0_done, m0_err, m1_gnt, m1_done, m1_err, s_valid, s_we});
    end
    n_checks++;
    if ({rdata, s_addr, s_wdata, s_size} !== 98'd0) begin
      n_fail++;
      $display("FAIL reset_data: rdata=%h s_addr=%h s_wdata=%h s_size=%b required all 0", rdata, s_addr, s_wdata, s_size);
    end
    rst_n = 1'b1;
    $display("reset: released");
  endtask

  task automatic test_contention();
    m0_req = 1; m0_addr = 32'h10; m0_size = 2'd2;
    m1_req = 1; m1_addr = 32'h20; m1_size = 2'd2;
    tick();
    n_checks++;
    if ({m0_gnt, m1_gnt, s_valid} !== 3'b101 || s_addr !== 32'h10) begin
      n_fail++;
      $display("FAIL cont_first: gnt=%b%b s_valid=%b s_addr=%h required 10 1 00000010", m0_gnt, m1_gnt, s_valid, s_addr);
    end
    s_ready = 1; s_rdata = 32'h11;
    tick();
    s_ready = 0;
    n_checks++;
    if ({m0_done, m1_done, m0_err, m0_gnt, m1_gnt} !== 5'b10000 || rdata !== 32'h11) begin
      n_fail++;
      $display("FAIL cont_done0: done=%b%b err=%b gnt=%b%b rdata=%h required 10 0 00 00000011", m0_done, m1_done, m0_err, m0_gnt, m1_gnt, rdata);
    end
    tick();
    n_checks++;
    if ({m0_gnt, m1_gnt, m0_done, m1_done, s_valid} !== 5'b00000) begin
      n_fail++;
      $display("FAIL cont_bubble: gnt=%b%b done=%b%b s_valid=%b required all 0", m0_gnt, m1_gnt, m0_done, m1_done, s_valid);
    end
    tick();
    n_checks++;
    if ({m0_gnt, m1_gnt} !== 2'b01 || s_addr !== 32'h20) begin
      n_fail++;
      $display("FAIL cont_second: gnt=%b%b s_addr=%h required 01 00000020", m0_gnt, m1_gnt, s_addr);
    end
    s_ready = 1; s_rdata = 32'h22;
    tick();
    s_ready = 0; m1_req = 0;
    n_checks++;
    if ({m0_done, m1_done, m1_err} !== 3'b010 || rdata !== 32'h22) begin
      n_fail++;
      $display("FAIL cont_done1: done=%b%b err=%b rdata=%h required 01 0 00000022", m0_done, m1_done, m1_err, rdata);
    end
    tick();
    tick();
    n_checks++;
    if ({m0_gnt, m1_gnt} !== 2'b10 || s_addr !== 32'h10) begin
      n_fail++;
      $display("FAIL cont_third: gnt=%b%b s_addr=%h required 10 00000010", m0_gnt, m1_gnt, s_addr);
    end
    s_ready = 1; s_rdata = 32'h33;
    tick();
    s_ready = 0; m0_req = 0;
    exp_rdata = 32'h33;
    n_checks++;
    if ({m0_done, m1_done} !== 2'b10 || rdata !== exp_rdata) begin
      n_fail++;
      $display("FAIL cont_done2: done=%b%b rdata=%h required 10 %h", m0_done, m1_done, rdata, exp_rdata);
    end
    tick();
    $display("contention: m0, m1, m0 served in order");
  endtask

  task automatic test_zero_wait();
    m0_req = 1; m0_we = 0; m0_addr = 32'h40; m0_size = 2'd2;
    tick();
    n_checks++;
    if ({m0_gnt, s_valid, s_we} !== 3'b110 || s_addr !== 32'h40) begin
      n_fail++;
      $display("FAIL zw_grant: gnt=%b s_valid=%b s_we=%b s_addr=%h required 1 1 0 00000040", m0_gnt, s_valid, s_we, s_addr);
    end
    s_ready = 1; s_rdata = 32'hDEADBEEF;
    tick();
    s_ready = 0; m0_req = 0;
    exp_rdata = 32'hDEADBEEF;
    n_checks++;
    if ({m0_done, m0_err, m0_gnt, s_valid} !== 4'b1000 || rdata !== exp_rdata) begin
      n_fail++;
      $display("FAIL zw_done: done=%b err=%b gnt=%b s_valid=%b rdata=%h required 1 0 0 0 %h", m0_done, m0_err, m0_gnt, s_valid, rdata, exp_rdata);
    end
    tick();
    n_checks++;
    if (m0_done !== 1'b0) begin
      n_fail++;
      $display("FAIL zw_pulse: m0_done=%b required 0", m0_done);
    end
    $display("zero_wait: m0 read 0x40 -> %h", rdata);
  endtask

  task automatic test_wait_states();
    s_ready = 1; s_rdata = 32'h99999999;
    tick();
    s_ready = 0;
    n_checks++;
    if ({m0_done, m1_done, s_valid} !== 3'b000 || rdata !== exp_rdata) begin
      n_fail++;
      $display("FAIL idle_ready: done=%b%b s_valid=%b rdata=%h required 00 0 %h", m0_done, m1_done, s_valid, rdata, exp_rdata);
    end
    m1_req = 1; m1_we = 1; m1_addr = 32'h100; m1_wdata = 32'h12345678; m1_size = 2'd2;
    tick();
    m1_addr = 32'hBAD0; m1_wdata = 32'h0; m1_we = 0;
    for (int i = 0; i < 4; i++) begin
      n_checks++;
      if ({s_valid, s_we, m1_gnt} !== 3'b111 || s_addr !== 32'h100 || s_wdata !== 32'h12345678 || s_size !== 2'd2) begin
        n_fail++;
        $display("FAIL ws_stable%0d: valid=%b we=%b gnt=%b addr=%h wdata=%h size=%0d required 1 1 1 00000100 12345678 2", i, s_valid, s_we, m1_gnt, s_addr, s_wdata, s_size);
      end
      s_rdata = 32'hFFFFFFFF;
      tick();
    end
    s_ready = 1; s_rdata = 32'hCAFEF00D;
    tick();
    s_ready = 0; m1_req = 0;
    n_checks++;
    if ({m1_done, m1_err, m0_done, s_valid} !== 4'b1000 || rdata !== exp_rdata) begin
      n_fail++;
      $display("FAIL ws_done: done1=%b err1=%b done0=%b valid=%b rdata=%h required 1 0 0 0 %h", m1_done, m1_err, m0_done, s_valid, rdata, exp_rdata);
    end
    tick();
    $display("wait_states: m1 write 0x100 done after 4 waits");
  endtask

  task automatic test_timeout();
    m0_req = 1; m0_we = 0; m0_addr = 32'h200;
    tick();
    for (int i = 1; i <= 15; i++) begin
      n_checks++;
      if ({s_valid, m0_gnt, m0_done} !== 3'b110) begin
        n_fail++;
        $display("FAIL to_busy%0d: valid=%b gnt=%b done=%b required 1 1 0", i, s_valid, m0_gnt, m0_done);
      end
      tick();
    end
    m0_req = 0;
    n_checks++;
    if ({s_valid, m0_done, m0_err, m1_done} !== 4'b0110 || rdata !== exp_rdata) begin
      n_fail++;
      $display("FAIL to_abort: valid=%b done=%b err=%b done1=%b rdata=%h required 0 1 1 0 %h", s_valid, m0_done, m0_err, m1_done, rdata, exp_rdata);
    end
    tick();
    m1_req = 1; m1_we = 0; m1_addr = 32'h300;
    tick();
    n_checks++;
    if ({m1_gnt, s_valid} !== 2'b11 || s_addr !== 32'h300) begin
      n_fail++;
      $display("FAIL to_next_gnt: gnt=%b valid=%b addr=%h required 1 1 00000300", m1_gnt, s_valid, s_addr);
    end
    s_ready = 1; s_rdata = 32'h55AA55AA;
    tick();
    s_ready = 0; m1_req = 0;
    exp_rdata = 32'h55AA55AA;
    n_checks++;
    if ({m1_done, m1_err} !== 2'b10 || rdata !== exp_rdata) begin
      n_fail++;
      $display("FAIL to_next_done: done=%b err=%b rdata=%h required 1 0 %h", m1_done, m1_err, rdata, exp_rdata);
    end
    tick();
    $display("timeout: m0 aborted after 15 cycles, m1 then served");
  endtask

  task automatic test_boundary();
    m0_req = 1; m0_we = 0; m0_addr = 32'h400;
    tick();
    for (int i = 1; i <= 14; i++) tick();
    n_checks++;
    if ({s_valid, m0_gnt} !== 2'b11) begin
      n_fail++;
      $display("FAIL bd_last_busy: valid=%b gnt=%b required 1 1", s_valid, m0_gnt);
    end
    s_ready = 1; s_rdata = 32'h0BADCAFE;
    tick();
    s_ready = 0; m0_req = 0;
    exp_rdata = 32'h0BADCAFE;
    n_checks++;
    if ({m0_done, m0_err, s_valid} !== 3'b100 || rdata !== exp_rdata) begin
      n_fail++;
      $display("FAIL bd_done: done=%b err=%b valid=%b rdata=%h required 1 0 0 %h", m0_done, m0_err, s_valid, rdata, exp_rdata);
    end
    tick();
    $display("boundary: ready on final cycle -> success rdata=%h", rdata);
  endtask

  task automatic test_reset_mid_busy();
    m0_req = 1; m0_addr = 32'h500;
    m1_req = 1; m1_addr = 32'h600;
    tick();
    n_checks++;
    if ({m0_gnt, m1_gnt, s_valid} !== 3'b011 || s_addr !== 32'h600) begin
      n_fail++;
      $display("FAIL rm_pre: gnt=%b%b valid=%b addr=%h required 01 1 00000600", m0_gnt, m1_gnt, s_valid, s_addr);
    end
    #3 rst_n = 1'b0;
    #1;
    n_checks++;
    if ({m0_gnt, m1_gnt, m0_done, m1_done, s_valid} !== 5'b00000 || rdata !== 32'h0) begin
      n_fail++;
      $display("FAIL rm_async: gnt=%b%b done=%b%b valid=%b rdata=%h required all 0", m0_gnt, m1_gnt, m0_done, m1_done, s_valid, rdata);
    end
    #2 rst_n = 1'b1;
    tick();
    n_checks++;
    if ({m0_gnt, m1_gnt, m0_done, m1_done} !== 4'b1000 || s_addr !== 32'h500) begin
      n_fail++;
      $display("FAIL rm_regrant: gnt=%b%b done=%b%b addr=%h required 10 00 00000500", m0_gnt, m1_gnt, m0_done, m1_done, s_addr);
    end
    m1_req = 0;
    s_ready = 1; s_rdata = 32'h77;
    tick();
    s_ready = 0; m0_req = 0;
    n_checks++;
    if ({m0_done, m1_done, m0_err} !== 3'b100 || rdata !== 32'h77) begin
      n_fail++;
      $display("FAIL rm_done: done=%b%b err=%b rdata=%h required 10 0 00000077", m0_done, m1_done, m0_err, rdata);
    end
    tick();
    $display("reset_mid_busy: outputs cleared, m0 won first grant after release");
  endtask

  initial begin
    test_reset();
    test_contention();
    test_zero_wait();
    test_wait_states();
    test_timeout();
    test_boundary();
    test_reset_mid_busy();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
